// File: rtl/game_pkg.sv
// Shared screen, colour and arbiter-state definitions for the game datapaths.
package game_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;

  localparam logic [C_W-1:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping around.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] sel,
  output logic             valid
);
  always_comb begin
    int unsigned idx;
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/plot_port_arbiter.sv
// Burst arbiter sharing the single VGA adapter write port among N_REQ draw/erase
// datapaths, with round-robin fairness and a per-grant burst-length watchdog.
module plot_port_arbiter
  import game_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int X_W       = game_pkg::X_W,
  parameter int Y_W       = game_pkg::Y_W,
  parameter int C_W       = game_pkg::C_W,
  parameter int MAX_BURST = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic [N_REQ-1:0]         plot_in,
  input  logic [N_REQ*X_W-1:0]     x_in,
  input  logic [N_REQ*Y_W-1:0]     y_in,
  input  logic [N_REQ*C_W-1:0]     colour_in,
  output logic [N_REQ-1:0]         grant,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     overrun,
  output logic [$clog2(N_REQ)-1:0] overrun_id
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0] grant_d;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;
  logic [C_W-1:0]   c_d;
  logic             plot_d;
  logic             overrun_d;
  logic [IDX_W-1:0] overrun_id_d;
  logic [IDX_W-1:0] pick_sel;
  logic             pick_valid;
  logic             exit_burst;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .sel    (pick_sel),
    .valid  (pick_valid)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    grant_d      = grant;
    x_d          = vga_x;
    y_d          = vga_y;
    c_d          = vga_colour;
    plot_d       = 1'b0;
    overrun_d    = overrun;
    overrun_id_d = overrun_id;
    exit_burst   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_sel] = 1'b1;
          g_d               = pick_sel;
          burst_cnt_d       = '0;
        end
      end
      GRANT: begin
        x_d    = x_in[int'(g_q)*X_W +: X_W];
        y_d    = y_in[int'(g_q)*Y_W +: Y_W];
        c_d    = colour_in[int'(g_q)*C_W +: C_W];
        plot_d = plot_in[g_q];
        if (plot_in[g_q]) burst_cnt_d = burst_cnt_q + 1'b1;
        // last beats a dropped req, which beats the watchdog
        if (plot_in[g_q] && last[g_q]) begin
          exit_burst = 1'b1;
        end else if (!req[g_q]) begin
          exit_burst = 1'b1;
        end else if (plot_in[g_q] && burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
          exit_burst   = 1'b1;
          overrun_d    = 1'b1;
          overrun_id_d = g_q;
        end
        if (exit_burst) begin
          state_d  = RELEASE;
          grant_d  = '0;
          rr_ptr_d = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      g_q         <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant       <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      overrun     <= 1'b0;
      overrun_id  <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant       <= grant_d;
      vga_x       <= x_d;
      vga_y       <= y_d;
      vga_colour  <= c_d;
      vga_plot    <= plot_d;
      overrun     <= overrun_d;
      overrun_id  <= overrun_id_d;
    end
  end
endmodule
